// File: rtl/udp_reg_pkg.sv
// Shared types and constants for the UDP register bank: FSM states, command
// characters and reply codes.
package udp_reg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_IDX,
        ST_CMD,
        ST_WDATA,
        ST_DRAIN,
        ST_RESP,
        ST_ECHO,
        ST_DROP
    } state_t;

    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_W_UP  = 8'h57;
    localparam logic [7:0] ASCII_W_LO  = 8'h77;
    localparam logic [7:0] ASCII_R_UP  = 8'h52;
    localparam logic [7:0] ASCII_R_LO  = 8'h72;
    localparam logic [7:0] ASCII_K     = 8'h4B;
    localparam logic [7:0] ASCII_E     = 8'h45;

    typedef enum logic [7:0] {
        REPLY_ACK = ASCII_K,
        REPLY_ERR = ASCII_E
    } reply_t;

endpackage

// File: rtl/udp_reg_tx_ser.sv
// Reply serialiser: loads up to NB left-aligned bytes plus a length and emits
// them MSB first on a registered AXI-Stream byte output.
module udp_reg_tx_ser #(
    parameter int unsigned NB = 4,
    parameter int unsigned LW = $clog2(NB + 1)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_load,
    input  logic [NB*8-1:0] i_load_data,
    input  logic [LW-1:0]   i_load_len,
    input  logic            i_load_last,
    output logic [7:0]      o_tdata,
    output logic            o_tvalid,
    output logic            o_tlast,
    input  logic            i_tready,
    output logic            o_done
);

    localparam int unsigned W = NB * 8;

    logic [W-1:0]  sh;
    logic [LW-1:0] rem;
    logic          last_q;

    // A load takes priority over an advancing handshake; the caller only loads
    // when the previous byte is leaving or the output is empty.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sh       <= '0;
            rem      <= '0;
            last_q   <= 1'b0;
            o_tdata  <= '0;
            o_tvalid <= 1'b0;
            o_tlast  <= 1'b0;
        end else if (i_load) begin
            o_tdata  <= i_load_data[W-1 -: 8];
            sh       <= i_load_data << 8;
            rem      <= i_load_len - LW'(1);
            last_q   <= i_load_last;
            o_tvalid <= 1'b1;
            o_tlast  <= i_load_last && (i_load_len == LW'(1));
        end else if (o_tvalid && i_tready) begin
            if (rem == '0) begin
                o_tdata  <= '0;
                o_tvalid <= 1'b0;
                o_tlast  <= 1'b0;
            end else begin
                o_tdata <= sh[W-1 -: 8];
                sh      <= sh << 8;
                rem     <= rem - LW'(1);
                o_tlast <= last_q && (rem == LW'(1));
            end
        end
    end

    assign o_done = o_tvalid && i_tready && o_tlast;

endmodule

// File: rtl/udp_reg_bank.sv
// UDP-controlled register bank: parses ':' idx cmd [data] packets, replies K/E
// or read data. Define UDP_REG_BANK_ECHO_EN to echo non-command packets.
module udp_reg_bank
    import udp_reg_pkg::*;
#(
    parameter int unsigned          NUM_REGS    = 8,
    parameter int unsigned          REG_WIDTH   = 32,
    parameter logic [NUM_REGS-1:0]  RO_MASK     = '0,
    parameter logic [REG_WIDTH-1:0] RST_VAL     = '0,
    parameter logic [31:0]          IP_ADDRESS  = {8'd192, 8'd168, 8'd1, 8'd128},
    parameter logic [15:0]          PORT_NUMBER = 16'd1234
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [7:0]                    i_rx_udp_payload_axis_tdata,
    input  logic                          i_rx_udp_payload_axis_tvalid,
    input  logic                          i_rx_udp_payload_axis_tlast,
    output logic                          o_rx_udp_payload_axis_tready,
    output logic [7:0]                    o_tx_udp_payload_axis_tdata,
    output logic                          o_tx_udp_payload_axis_tvalid,
    output logic                          o_tx_udp_payload_axis_tlast,
    input  logic                          i_tx_udp_payload_axis_tready,
    input  logic [31:0]                   i_ip_adr,
    input  logic [15:0]                   i_port_nbr,
    output logic [NUM_REGS*REG_WIDTH-1:0] o_regs,
    output logic [NUM_REGS-1:0]           o_wr_strobe
);

    localparam int unsigned NB = REG_WIDTH / 8;
    localparam int unsigned CW = $clog2(NB + 1);
    localparam int unsigned IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    state_t               state;
    logic [IW-1:0]        idx;
    logic                 err;
    logic [CW-1:0]        cnt;
    logic [REG_WIDTH-1:0] acc;
    logic [REG_WIDTH-1:0] snap;
    logic [REG_WIDTH-1:0] regs [NUM_REGS];
    logic [REG_WIDTH-1:0] wval;

    logic [7:0]           rx_data;
    logic                 rx_hs, rx_last, src_ok;
    logic                 is_colon, is_w, is_r;

    logic                 ld, ld_last, ser_done;
    logic [REG_WIDTH-1:0] ld_data;
    logic [CW-1:0]        ld_len;

    function automatic logic [REG_WIDTH-1:0] top_byte(input logic [7:0] b);
        return REG_WIDTH'(b) << (REG_WIDTH - 8);
    endfunction

    assign rx_data  = i_rx_udp_payload_axis_tdata;
    assign rx_last  = i_rx_udp_payload_axis_tlast;
    assign rx_hs    = i_rx_udp_payload_axis_tvalid && o_rx_udp_payload_axis_tready;
    assign src_ok   = (i_ip_adr == IP_ADDRESS) && (i_port_nbr == PORT_NUMBER);
    assign is_colon = (rx_data == ASCII_COLON);
    assign is_w     = (rx_data == ASCII_W_UP) || (rx_data == ASCII_W_LO);
    assign is_r     = (rx_data == ASCII_R_UP) || (rx_data == ASCII_R_LO);
    assign wval     = (acc << 8) | REG_WIDTH'(rx_data);

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
        assign o_regs[g*REG_WIDTH +: REG_WIDTH] = regs[g];
    end

    always_comb begin
        case (state)
            ST_RESP: o_rx_udp_payload_axis_tready = 1'b0;
`ifdef UDP_REG_BANK_ECHO_EN
            ST_ECHO: o_rx_udp_payload_axis_tready = !o_tx_udp_payload_axis_tvalid ||
                                                    i_tx_udp_payload_axis_tready;
`endif
            default: o_rx_udp_payload_axis_tready = 1'b1;
        endcase
    end

    // Reply load is decided on the accepting beat so the first reply byte is
    // valid in the very next cycle.
    always_comb begin
        ld      = 1'b0;
        ld_data = top_byte(REPLY_ERR);
        ld_len  = CW'(1);
        ld_last = 1'b1;
        case (state)
            ST_IDLE: begin
                if (rx_hs && src_ok && is_colon) ld = rx_last;
`ifdef UDP_REG_BANK_ECHO_EN
                if (rx_hs && src_ok && !is_colon) begin
                    ld      = 1'b1;
                    ld_data = top_byte(rx_data);
                    ld_last = rx_last;
                end
`endif
            end
            ST_IDX: ld = rx_hs && rx_last;
            ST_CMD: begin
                if (rx_hs && rx_last) begin
                    ld = 1'b1;
                    if (!err && is_r) begin
                        ld_data = regs[idx];
                        ld_len  = CW'(NB);
                    end
                end
            end
            ST_WDATA: begin
                if (rx_hs && rx_last) begin
                    ld = 1'b1;
                    if (cnt == CW'(NB - 1)) ld_data = top_byte(REPLY_ACK);
                end
            end
            ST_DRAIN: begin
                if (rx_hs && rx_last) begin
                    ld = 1'b1;
                    if (!err) begin
                        ld_data = snap;
                        ld_len  = CW'(NB);
                    end
                end
            end
`ifdef UDP_REG_BANK_ECHO_EN
            ST_ECHO: begin
                if (rx_hs) begin
                    ld      = 1'b1;
                    ld_data = top_byte(rx_data);
                    ld_last = rx_last;
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= ST_IDLE;
            idx         <= '0;
            err         <= 1'b0;
            cnt         <= '0;
            acc         <= '0;
            snap        <= '0;
            o_wr_strobe <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= RST_VAL;
        end else begin
            o_wr_strobe <= '0;
            case (state)
                ST_IDLE: begin
                    if (rx_hs) begin
                        err <= 1'b0;
                        cnt <= '0;
                        if (!src_ok)       state <= rx_last ? ST_IDLE : ST_DROP;
                        else if (is_colon) state <= rx_last ? ST_RESP : ST_IDX;
`ifdef UDP_REG_BANK_ECHO_EN
                        else               state <= rx_last ? ST_RESP : ST_ECHO;
`else
                        else               state <= rx_last ? ST_IDLE : ST_DROP;
`endif
                    end
                end
                ST_IDX: begin
                    if (rx_hs) begin
                        idx   <= rx_data[IW-1:0];
                        err   <= (32'(rx_data) >= NUM_REGS);
                        state <= rx_last ? ST_RESP : ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (rx_hs) begin
                        if (err) begin
                            state <= rx_last ? ST_RESP : ST_DRAIN;
                        end else if (is_r) begin
                            snap  <= regs[idx];
                            state <= rx_last ? ST_RESP : ST_DRAIN;
                        end else if (is_w && !RO_MASK[idx]) begin
                            state <= rx_last ? ST_RESP : ST_WDATA;
                        end else begin
                            err   <= 1'b1;
                            state <= rx_last ? ST_RESP : ST_DRAIN;
                        end
                    end
                end
                ST_WDATA: begin
                    if (rx_hs) begin
                        acc <= wval;
                        cnt <= cnt + CW'(1);
                        if (rx_last) begin
                            if (cnt == CW'(NB - 1)) begin
                                regs[idx]        <= wval;
                                o_wr_strobe[idx] <= 1'b1;
                            end
                            state <= ST_RESP;
                        end else if (cnt == CW'(NB)) begin
                            err   <= 1'b1;
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: if (rx_hs && rx_last) state <= ST_RESP;
                ST_DROP:  if (rx_hs && rx_last) state <= ST_IDLE;
`ifdef UDP_REG_BANK_ECHO_EN
                ST_ECHO:  if (rx_hs && rx_last) state <= ST_RESP;
`endif
                ST_RESP:  if (ser_done) state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    udp_reg_tx_ser #(
        .NB (NB),
        .LW (CW)
    ) u_tx_ser (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_load      (ld),
        .i_load_data (ld_data),
        .i_load_len  (ld_len),
        .i_load_last (ld_last),
        .o_tdata     (o_tx_udp_payload_axis_tdata),
        .o_tvalid    (o_tx_udp_payload_axis_tvalid),
        .o_tlast     (o_tx_udp_payload_axis_tlast),
        .i_tready    (i_tx_udp_payload_axis_tready),
        .o_done      (ser_done)
    );

endmodule

// File: tb/tb_udp_reg_bank.sv
// Self-checking bench for udp_reg_bank: directed protocol cases followed by
// randomized packets checked against a packet-level reference model.
module tb_udp_reg_bank;

    localparam int unsigned     NREG = 8;
    localparam int unsigned     RW   = 32;
    localparam int unsigned     NB   = RW / 8;
    localparam logic [NREG-1:0] RO   = 8'b0000_1000;
    localparam logic [RW-1:0]   RV   = 32'hA5A5_0F0F;
    localparam logic [31:0]     IP   = {8'd192, 8'd168, 8'd1, 8'd128};
    localparam logic [15:0]     PORT = 16'd1234;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [7:0]           rx_data = '0;
    logic                 rx_valid = 1'b0;
    logic                 rx_last = 1'b0;
    logic                 rx_ready;
    logic [7:0]           tx_data;
    logic                 tx_valid, tx_last;
    logic                 tx_ready = 1'b1;
    logic [31:0]          ip_adr = IP;
    logic [15:0]          port_nbr = PORT;
    logic [NREG*RW-1:0]   regs;
    logic [NREG-1:0]      strobe;

    udp_reg_bank #(
        .NUM_REGS    (NREG),
        .REG_WIDTH   (RW),
        .RO_MASK     (RO),
        .RST_VAL     (RV),
        .IP_ADDRESS  (IP),
        .PORT_NUMBER (PORT)
    ) dut (
        .i_clk                        (clk),
        .i_rst_n                      (rst_n),
        .i_rx_udp_payload_axis_tdata  (rx_data),
        .i_rx_udp_payload_axis_tvalid (rx_valid),
        .i_rx_udp_payload_axis_tlast  (rx_last),
        .o_rx_udp_payload_axis_tready (rx_ready),
        .o_tx_udp_payload_axis_tdata  (tx_data),
        .o_tx_udp_payload_axis_tvalid (tx_valid),
        .o_tx_udp_payload_axis_tlast  (tx_last),
        .i_tx_udp_payload_axis_tready (tx_ready),
        .i_ip_adr                     (ip_adr),
        .i_port_nbr                   (port_nbr),
        .o_regs                       (regs),
        .o_wr_strobe                  (strobe)
    );

    always #5 clk = ~clk;

    int              checks = 0;
    int              failures = 0;
    int              stall_err = 0;
    logic [8:0]      got_q[$];
    logic [NREG-1:0] strobe_q[$];
    logic            bp_q[$];
    logic [RW-1:0]   mregs[NREG];
    logic            prev_stall = 1'b0;
    logic [8:0]      prev_beat = '0;
    logic [7:0]      cmds[6] = '{8'h57, 8'h77, 8'h52, 8'h72, 8'h58, 8'h57};

    // Collect reply beats and strobe pulses; flag any change while stalled.
    always @(negedge clk) begin
        if (prev_stall && !(tx_valid && ({tx_last, tx_data} == prev_beat))) stall_err++;
        prev_stall = tx_valid && !tx_ready;
        prev_beat  = {tx_last, tx_data};
        if (tx_valid && tx_ready) got_q.push_back({tx_last, tx_data});
        if (strobe != '0) strobe_q.push_back(strobe);
    end

    always @(posedge clk) begin
        #1;
        tx_ready = (bp_q.size() > 0) ? bp_q.pop_front() : 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NREG*RW-1:0] packed_model();
        logic [NREG*RW-1:0] v;
        for (int i = 0; i < NREG; i++) v[i*RW +: RW] = mregs[i];
        return v;
    endfunction

    // Packet-level rules: returns expected reply beats and strobe, updates model.
    function automatic void model(input logic [7:0] p[$], input logic src_ok,
                                  output logic [8:0] rep[$], output logic [NREG-1:0] stb);
        logic [RW-1:0] val;
        rep = {};
        stb = '0;
        if (!src_ok) return;
        if (p[0] != 8'h3A) begin
`ifdef UDP_REG_BANK_ECHO_EN
            foreach (p[i]) rep.push_back({i == p.size() - 1, p[i]});
`endif
            return;
        end
        if (p.size() < 3 || p[1] >= NREG) begin
            rep.push_back({1'b1, 8'h45});
            return;
        end
        if (p[2] == 8'h52 || p[2] == 8'h72) begin
            for (int k = NB - 1; k >= 0; k--) rep.push_back({k == 0, mregs[p[1]][k*8 +: 8]});
        end else if ((p[2] == 8'h57 || p[2] == 8'h77) && !RO[p[1]] && p.size() == 3 + NB) begin
            val = '0;
            for (int k = 0; k < NB; k++) val = (val << 8) | RW'(p[3 + k]);
            mregs[p[1]] = val;
            stb[p[1]] = 1'b1;
            rep.push_back({1'b1, 8'h4B});
        end else begin
            rep.push_back({1'b1, 8'h45});
        end
    endfunction

    task automatic send(input logic [7:0] p[$], input int unsigned nsend);
        @(posedge clk);
        #1;
        for (int unsigned i = 0; i < nsend; i++) begin
            int unsigned t = 0;
            logic acc = 1'b0;
            rx_data  = p[i];
            rx_valid = 1'b1;
            rx_last  = (i == p.size() - 1);
            while (!acc && t < 200) begin
                @(negedge clk);
                acc = rx_ready;
                @(posedge clk);
                #1;
                t++;
            end
            check("rx_accept", {255'b0, acc}, 256'd1);
        end
        rx_valid = 1'b0;
        rx_last  = 1'b0;
    endtask

    task automatic expect_reply(input logic [8:0] exp[$], input string tag);
        int unsigned t = 0;
        while (got_q.size() < exp.size() && t < 300) begin
            @(negedge clk);
            t++;
        end
        repeat (6) @(negedge clk);
        check({tag, "_len"}, got_q.size(), exp.size());
        for (int i = 0; i < exp.size(); i++)
            check($sformatf("%s_b%0d", tag, i), (i < got_q.size()) ? got_q[i] : 9'h1FF, exp[i]);
        got_q.delete();
    endtask

    task automatic run_pkt(input logic [7:0] p[$], input logic [15:0] port,
                           input bit chk_lat, input string tag);
        logic [8:0]      rep[$];
        logic [NREG-1:0] stb;
        model(p, port == PORT, rep, stb);
        port_nbr = port;
        send(p, p.size());
        if (chk_lat) begin
            @(negedge clk);
            check({tag, "_latency"}, {255'b0, tx_valid}, 256'd1);
        end
        expect_reply(rep, tag);
        check({tag, "_strobe_n"}, strobe_q.size(), (stb != '0) ? 1 : 0);
        check({tag, "_strobe"}, (strobe_q.size() > 0) ? strobe_q[0] : '0, stb);
        check({tag, "_regs"}, regs, packed_model());
        strobe_q.delete();
        port_nbr = PORT;
    endtask

    initial begin
        logic [7:0] p[$];
        foreach (mregs[i]) mregs[i] = RV;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_regs", regs, {NREG{RV}});
        check("rst_strobe", strobe, '0);
        check("rst_tx", {tx_valid, tx_last, tx_data}, '0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        run_pkt('{8'h3A, 8'h05, 8'h57, 8'hDE, 8'hAD, 8'hBE, 8'hEF}, PORT, 1'b1, "wr5");
        check("wr5_field", regs[191:160], 32'hDEADBEEF);
        run_pkt('{8'h3A, 8'h05, 8'h72}, PORT, 1'b1, "rd5");
        run_pkt('{8'h3A, 8'h08, 8'h52}, PORT, 1'b0, "bad_idx");
        run_pkt('{8'h3A, 8'h02, 8'h58}, PORT, 1'b0, "bad_cmd");
        run_pkt('{8'h3A, 8'h03, 8'h57, 8'h01, 8'h02, 8'h03, 8'h04}, PORT, 1'b0, "ro_wr");
        run_pkt('{8'h3A, 8'h01, 8'h57, 8'h01, 8'h02, 8'h03}, PORT, 1'b0, "short_wr");
        run_pkt('{8'h3A, 8'h01, 8'h57, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05}, PORT, 1'b0, "long_wr");
        run_pkt('{8'h3A}, PORT, 1'b0, "colon_only");
        run_pkt('{8'h3A, 8'h02, 8'h57, 8'h11, 8'h22, 8'h33, 8'h44}, 16'd1235, 1'b0, "filter");
        run_pkt('{8'h3A, 8'h05, 8'h52, 8'h00, 8'h00}, PORT, 1'b0, "rd_drain");

        bp_q = '{1, 1, 1, 1, 0, 0, 1, 0, 0, 1, 1, 0, 1};
        run_pkt('{8'h3A, 8'h05, 8'h52}, PORT, 1'b0, "rd_bp");
        check("bp_stable", stall_err, 0);

        run_pkt('{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F}, PORT, 1'b0, "echo");

        p = '{8'h3A, 8'h01, 8'h57, 8'h11, 8'h22, 8'h33, 8'h44};
        send(p, 5);
        rst_n = 1'b0;
        foreach (mregs[i]) mregs[i] = RV;
        repeat (2) @(negedge clk);
        check("midrst_regs", regs, {NREG{RV}});
        check("midrst_tx", {tx_valid, tx_last, tx_data}, '0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        strobe_q.delete();
        got_q.delete();
        run_pkt('{8'h3A, 8'h01, 8'h57, 8'hCA, 8'hFE, 8'hF0, 8'h0D}, PORT, 1'b0, "post_rst_wr");

        for (int n = 0; n < 40; n++) begin
            int unsigned kind = $urandom_range(0, 9);
            int unsigned len;
            p = {};
            p.push_back((kind == 0) ? 8'(8'h41 + $urandom_range(0, 25)) : 8'h3A);
            p.push_back(8'($urandom_range(0, 9)));
            p.push_back(cmds[$urandom_range(0, 5)]);
            len = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 6) : NB;
            for (int unsigned k = 0; k < len; k++) p.push_back(8'($urandom));
            if ($urandom_range(0, 2) == 0)
                for (int k = 0; k < 8; k++) bp_q.push_back(1'($urandom));
            run_pkt(p, (kind == 1) ? PORT + 16'd1 : PORT, 1'b0, $sformatf("rnd%0d", n));
        end
        check("rnd_bp_stable", stall_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
